// File: rtl/mac_result_accumulator.sv
// Frame accumulator for the multiply-add stage: sums unsigned terms until in_last,
// then holds the saturated total, term count and overflow flag until the consumer takes it.
module mac_result_accumulator #(
  parameter int IN_W    = 24,
  parameter int ACC_W   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_overflow
);

  // state | meaning
  // ACC   | accepting terms, accumulating the current frame
  // OUT   | frame result presented, waiting for out_ready
  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W:0]     sum_wide;
  logic               carry;
  logic [ACC_W-1:0]   sum_sat;
  logic [COUNT_W-1:0] cnt_inc;
  logic               accept;

  assign in_ready = (state_q == S_ACC);
  assign accept   = in_valid && in_ready;

  // An accumulator already pinned at all-ones counts as a carry so ovf stays honest.
  assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign carry    = sum_wide[ACC_W] | (&acc_q);
  assign sum_sat  = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          if (in_last) begin
            out_data_d  = sum_sat;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | carry;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = S_OUT;
          end else begin
            acc_d = sum_sat;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
          end
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Scoreboard bench for mac_result_accumulator: a reference model pushes frame results
// as terms are accepted; a negedge monitor pops and compares on each output handshake.
module tb_mac_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        out_overflow;

  mac_result_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_acc = '0;
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [23:0] d, input logic last);
    longint s;
    exp_t   e;
    s = longint'(m_acc) + longint'(d);
    if (s > 64'hFFFF_FFFF || m_acc == 32'hFFFF_FFFF) begin
      m_acc = 32'hFFFF_FFFF;
      m_ovf = 1'b1;
    end else begin
      m_acc = s[31:0];
    end
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (last) begin
      e.data = m_acc;
      e.cnt  = m_cnt;
      e.ovf  = m_ovf;
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // Returns #1 after the accepting posedge, with in_valid dropped.
  task automatic send(input logic [23:0] d, input logic last);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    budget   = 50;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      check_val("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(d, last);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("out_data", 64'(out_data), 64'(e.data));
        check_val("out_count", 64'(out_count), 64'(e.cnt));
        check_val("out_overflow", 64'(out_overflow), 64'(e.ovf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_out_count", 64'(out_count), 64'd0);
    check_val("rst_out_ovf", 64'(out_overflow), 64'd0);
    rst_n = 1'b1;

    // basic frame, one-cycle bubble
    send(24'd100, 1'b0);
    send(24'd200, 1'b0);
    send(24'd300, 1'b1);
    check_val("f1_out_valid_rise", 64'(out_valid), 64'd1);
    check_val("f1_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check_val("f1_in_ready_back", 64'(in_ready), 64'd1);
    check_val("f1_out_valid_drop", 64'(out_valid), 64'd0);
    check_val("f1_data_kept", 64'(out_data), 64'd600);

    // single-term frame then a short one
    send(24'hABCDEF, 1'b1);
    send(24'd5, 1'b0);
    send(24'd7, 1'b1);

    // saturation frame followed by a clean frame
    for (int i = 0; i < 257; i++) send(24'hFFFFFF, i == 256);
    send(24'd1, 1'b1);

    // back-pressure hold
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(24'd10, 1'b0);
    send(24'd20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_val("hold_out_valid", 64'(out_valid), 64'd1);
      check_val("hold_out_data", 64'(out_data), 64'd30);
      check_val("hold_out_count", 64'(out_count), 64'd2);
      check_val("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_data  = 24'd99;
      in_last  = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("hold_release_in_ready", 64'(in_ready), 64'd1);
    check_val("hold_release_out_valid", 64'(out_valid), 64'd0);

    // gapped input
    send(24'd4, 1'b0);
    repeat (3) @(posedge clk);
    send(24'd6, 1'b1);

    // reset mid-frame discards partial sum
    send(24'd1, 1'b0);
    send(24'd2, 1'b0);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(24'd9, 1'b1);

    // reset while a result is pending
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(24'd3, 1'b1);
    check_val("pend_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    check_val("rst_out_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_data_clr", 64'(out_data), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(24'd2, 1'b1);

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
